// File: rtl/masked_and_share_feeder.sv
// Upstream share generator for the two-share masked AND gate. It splits operands a/b into
// Boolean shares using LFSR randomness and also supplies the gate's refresh bit.
module masked_and_share_feeder #(
   parameter int                LFSR_W    = 16,
   parameter logic [LFSR_W-1:0] TAPS      = 16'hB400,
   parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
   parameter int                REFRESH_N = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              seed_load,
   input  logic [LFSR_W-1:0] seed_in,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              a,
   input  logic              b,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              a0,
   output logic              a1,
   output logic              b0,
   output logic              b1,
   output logic              rN,
   output logic              gate_valid,
   output logic              reseed_req
);

   localparam int               CNT_W   = $clog2(REFRESH_N + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_N);

   logic [LFSR_W-1:0] lfsr_q;
   logic [LFSR_W-1:0] s1, s2, s3;
   logic [CNT_W-1:0]  xfer_cnt;
   logic [CNT_W-1:0]  cnt_next;
   logic              fire_in;
   logic              f1, f2, f3;

   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
      return {s[LFSR_W-2:0], ^(s & TAPS)};
   endfunction

   // Three LFSR steps per accepted pair: f1 masks a, f2 masks b, f3 is the refresh bit.
   always_comb begin
      s1 = lfsr_step(lfsr_q);
      s2 = lfsr_step(s1);
      s3 = lfsr_step(s2);
      f1 = s1[0];
      f2 = s2[0];
      f3 = s3[0];
   end

   assign in_ready = !rst && !seed_load && (!out_valid || out_ready);
   assign fire_in  = in_valid && in_ready;
   assign cnt_next = (xfer_cnt == CNT_MAX) ? xfer_cnt : xfer_cnt + 1'b1;

   // Share outputs are deliberately left unchanged on drain because the gate samples them every cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q     <= SEED;
         out_valid  <= 1'b0;
         a0         <= 1'b0;
         a1         <= 1'b0;
         b0         <= 1'b0;
         b1         <= 1'b0;
         rN         <= 1'b0;
         gate_valid <= 1'b0;
         xfer_cnt   <= '0;
         reseed_req <= 1'b0;
      end else begin
         gate_valid <= out_valid && out_ready;
         if (seed_load) begin
            lfsr_q     <= (seed_in == '0) ? SEED : seed_in;
            xfer_cnt   <= '0;
            reseed_req <= 1'b0;
            if (out_ready)
               out_valid <= 1'b0;
         end else if (fire_in) begin
            lfsr_q     <= s3;
            a0         <= a ^ f1;
            a1         <= f1;
            b0         <= b ^ f2;
            b1         <= f2;
            rN         <= f3;
            out_valid  <= 1'b1;
            xfer_cnt   <= cnt_next;
            reseed_req <= (cnt_next == CNT_MAX);
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
